// File: rtl/sum_seq_pkg.sv
// Shared types and constants for the sum entry sequencer.
// Key codes, display selects and the controller state encoding.
package sum_seq_pkg;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    ADD_REQ,
    SHOW
  } state_e;

  localparam logic [3:0] KEY_MAX_DIG = 4'h9;
  localparam logic [3:0] KEY_PLUS    = 4'hA;
  localparam logic [3:0] KEY_EQ      = 4'hB;
  localparam logic [3:0] KEY_CLR     = 4'hC;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_MAX_DIG;
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal operand accumulator: shift-add digits up to a digit limit.
// Clear and a digit in the same cycle restart the operand at that digit.
module dec_accum #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 2
) (
  input  logic              clk,
  input  logic              clear_i,
  input  logic              load_digit_i,
  input  logic [3:0]        digit_i,
  input  logic              load_value_i,
  input  logic [DATA_W-1:0] value_i,
  output logic [DATA_W-1:0] value_o,
  output logic [DATA_W-1:0] value_d_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DATA_W-1:0] TEN = DATA_W'(10);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic [DATA_W-1:0] val_q, val_d, base;
  logic [CNT_W-1:0]  cnt_q, cnt_d, base_cnt;

  // Next operand value and digit count.
  always_comb begin
    base     = clear_i ? '0 : val_q;
    base_cnt = clear_i ? '0 : cnt_q;
    val_d    = base;
    cnt_d    = base_cnt;
    if (load_digit_i) begin
      if (base_cnt < CNT_MAX) begin
        val_d = base * TEN + DATA_W'(digit_i);
        cnt_d = base_cnt + 1'b1;
      end
    end else if (load_value_i) begin
      val_d = value_i;
      cnt_d = '0;
    end
  end

  // Operand and counter registers; reset arrives through clear_i.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    cnt_q <= cnt_d;
  end

  assign value_o   = val_q;
  assign value_d_o = val_d;

endmodule

// File: rtl/sum_entry_sequencer.sv
// Keypad-to-adder controller: builds two decimal operands,
// runs one req/ack add and selects what the display shows.
module sum_entry_sequencer
  import sum_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MAX_DIGITS  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_req,
  input  logic              add_ack,
  input  logic [DATA_W-1:0] add_sum,
  input  logic              add_cout,
  output logic [DATA_W-1:0] disp_value,
  output logic [1:0]        disp_sel,
  output logic              busy,
  output logic              ovf_flag,
  output logic              err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        sel_q, sel_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              k_dig, k_plus, k_eq, k_clr;
  logic              a_clr, a_dig, a_ld;
  logic              b_clr, b_dig;
  logic [DATA_W-1:0] a_val, a_next, b_next;

  // Key strobe decode.
  always_comb begin
    k_dig  = 1'b0;
    k_plus = 1'b0;
    k_eq   = 1'b0;
    k_clr  = 1'b0;
    if (key_valid) begin
      unique case (1'b1)
        is_digit(key_code):   k_dig  = 1'b1;
        key_code == KEY_PLUS: k_plus = 1'b1;
        key_code == KEY_EQ:   k_eq   = 1'b1;
        key_code == KEY_CLR:  k_clr  = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state, operand commands and flags; clear overrides all.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    a_clr   = 1'b0;
    a_dig   = 1'b0;
    a_ld    = 1'b0;
    a_val   = res_q;
    b_clr   = 1'b0;
    b_dig   = 1'b0;
    unique case (state_q)
      ENTER_A: begin
        if (k_dig) begin
          a_dig = 1'b1;
        end else if (k_plus) begin
          b_clr   = 1'b1;
          state_d = ENTER_B;
          sel_d   = DISP_B;
        end
      end
      ENTER_B: begin
        if (k_dig) begin
          b_dig = 1'b1;
        end else if (k_eq) begin
          state_d = ADD_REQ;
          tmo_d   = '0;
        end
      end
      ADD_REQ: begin
        if (add_ack) begin
          res_d   = add_sum;
          ovf_d   = add_cout;
          state_d = SHOW;
          sel_d   = DISP_RES;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = SHOW;
          sel_d   = DISP_RES;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHOW: begin
        if (k_dig) begin
          a_clr   = 1'b1;
          a_dig   = 1'b1;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ENTER_A;
          sel_d   = DISP_A;
        end else if (k_plus && !ovf_q) begin
          a_ld    = 1'b1;
          b_clr   = 1'b1;
          state_d = ENTER_B;
          sel_d   = DISP_B;
        end
      end
    endcase
    if (k_clr || rst) begin
      state_d = ENTER_A;
      res_d   = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      tmo_d   = '0;
      sel_d   = DISP_A;
      a_clr   = 1'b1;
      a_dig   = 1'b0;
      a_ld    = 1'b0;
      b_clr   = 1'b1;
      b_dig   = 1'b0;
    end
  end

  // Display mux uses next values so the display tracks updates at once.
  always_comb begin
    case (sel_d)
      DISP_A:  disp_d = a_next;
      DISP_B:  disp_d = b_next;
      default: disp_d = res_d;
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTER_A;
      res_q   <= '0;
      disp_q  <= '0;
      tmo_q   <= '0;
      sel_q   <= DISP_A;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      tmo_q   <= tmo_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  dec_accum #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAX_DIGITS)
  ) u_acc_a (
    .clk         (clk),
    .clear_i     (a_clr),
    .load_digit_i(a_dig),
    .digit_i     (key_code),
    .load_value_i(a_ld),
    .value_i     (a_val),
    .value_o     (add_a),
    .value_d_o   (a_next)
  );

  dec_accum #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAX_DIGITS)
  ) u_acc_b (
    .clk         (clk),
    .clear_i     (b_clr),
    .load_digit_i(b_dig),
    .digit_i     (key_code),
    .load_value_i(1'b0),
    .value_i     ('0),
    .value_o     (add_b),
    .value_d_o   (b_next)
  );

  assign add_req    = (state_q == ADD_REQ);
  assign busy       = (state_q == ADD_REQ);
  assign ovf_flag   = ovf_q;
  assign err        = err_q;
  assign disp_sel   = sel_q;
  assign disp_value = disp_q;

endmodule

// File: tb/tb_sum_entry_sequencer.sv
// Bench for sum_entry_sequencer: directed scenarios plus random keys,
// checked every cycle against an integer-level calculator model.
module tb_sum_entry_sequencer;

  localparam int DW  = 8;
  localparam int MD  = 2;
  localparam int TMO = 15;

  localparam int M_EA = 0;
  localparam int M_EB = 1;
  localparam int M_AR = 2;
  localparam int M_SH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [DW-1:0] add_a, add_b;
  logic          add_req;
  logic          add_ack;
  logic [DW-1:0] add_sum;
  logic          add_cout;
  logic [DW-1:0] disp_value;
  logic [1:0]    disp_sel;
  logic          busy, ovf_flag, err;

  int total = 0;
  int bad   = 0;

  int m_st, mA, mB, mCnt, mRes, mOvf, mErr, mWait, mSel;
  int ack_mode = -1;
  int ack_dly  = 0;

  sum_entry_sequencer #(
    .DATA_W     (DW),
    .MAX_DIGITS (MD),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_req   (add_req),
    .add_ack   (add_ack),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .disp_value(disp_value),
    .disp_sel  (disp_sel),
    .busy      (busy),
    .ovf_flag  (ovf_flag),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st  = M_EA;
    mA    = 0;
    mB    = 0;
    mCnt  = 0;
    mRes  = 0;
    mOvf  = 0;
    mErr  = 0;
    mWait = 0;
    mSel  = 0;
  endtask

  task automatic m_step(input bit kv, input int kc, input bit r,
                        input bit ack, input int sum, input int cout);
    bit dig, plus, eq, clrk;
    dig  = kv && kc <= 9;
    plus = kv && kc == 10;
    eq   = kv && kc == 11;
    clrk = kv && kc == 12;
    if (r || clrk) begin
      m_reset();
      return;
    end
    case (m_st)
      M_EA: begin
        if (dig) begin
          if (mCnt < MD) begin
            mA = mA * 10 + kc;
            mCnt++;
          end
        end else if (plus) begin
          mB = 0; mCnt = 0; m_st = M_EB; mSel = 1;
        end
      end
      M_EB: begin
        if (dig) begin
          if (mCnt < MD) begin
            mB = mB * 10 + kc;
            mCnt++;
          end
        end else if (eq) begin
          m_st = M_AR; mWait = 0;
        end
      end
      M_AR: begin
        if (ack) begin
          mRes = sum; mOvf = cout; m_st = M_SH; mSel = 2;
        end else begin
          mWait++;
          if (mWait == TMO) begin
            mErr = 1; mRes = 0; m_st = M_SH; mSel = 2;
          end
        end
      end
      default: begin
        if (dig) begin
          mA = kc; mCnt = 1; mOvf = 0; mErr = 0;
          m_st = M_EA; mSel = 0;
        end else if (plus && mOvf == 0) begin
          mA = mRes; mB = 0; mCnt = 0; m_st = M_EB; mSel = 1;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit kv, input logic [3:0] kc,
                     input bit r, input bit force_ack);
    int s, prev, ed;
    s         = mA + mB;
    key_valid = kv;
    key_code  = kc;
    rst       = r;
    add_sum   = DW'(s % 256);
    add_cout  = (s >= 256);
    add_ack   = (m_st == M_AR) && (force_ack || mWait == ack_dly);
    prev      = m_st;
    @(posedge clk);
    m_step(kv, int'(kc), r, add_ack, s % 256, (s >= 256) ? 1 : 0);
    if (m_st == M_AR && prev != M_AR) begin
      if (ack_mode >= 0)
        ack_dly = ack_mode;
      else if ($urandom_range(0, 7) == 0)
        ack_dly = 1000;
      else
        ack_dly = int'($urandom_range(0, 4));
    end
    #1;
    ed = (mSel == 0) ? mA : (mSel == 1) ? mB : mRes;
    chk("add_a", add_a, mA);
    chk("add_b", add_b, mB);
    chk("add_req", add_req, m_st == M_AR);
    chk("busy", busy, m_st == M_AR);
    chk("disp_sel", disp_sel, mSel);
    chk("disp_value", disp_value, ed);
    chk("ovf_flag", ovf_flag, mOvf);
    chk("err", err, mErr);
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b1, k, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    logic [3:0] kc;
    int w;
    key_valid = 1'b0;
    key_code  = 4'h0;
    rst       = 1'b1;
    add_ack   = 1'b0;
    add_sum   = '0;
    add_cout  = 1'b0;
    m_reset();

    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("rst_disp", disp_value, 0);
    chk("rst_req", add_req, 0);

    // 12 + 34 with a two-cycle adder
    ack_mode = 2;
    press(4'h1); press(4'h2); press(4'hA);
    press(4'h3); press(4'h4);
    chk("op_a12", add_a, 12);
    chk("op_b34", add_b, 34);
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    chk("req_lat", add_req, 1);
    idle(5);
    chk("sum46", disp_value, 46);
    chk("sel_res", disp_sel, 2);
    chk("ovf0", ovf_flag, 0);

    // 99 + 99, then chained + 99 wraps with carry
    press(4'hC);
    press(4'h9); press(4'h9); press(4'hA);
    press(4'h9); press(4'h9); press(4'hB);
    idle(6);
    chk("sum198", disp_value, 198);
    press(4'hA); press(4'h9); press(4'h9); press(4'hB);
    idle(6);
    chk("sum41", disp_value, 41);
    chk("ovf1", ovf_flag, 1);
    press(4'hA);
    chk("plus_ign", disp_sel, 2);

    // third digit ignored
    press(4'hC);
    press(4'h7); press(4'h8); press(4'h9);
    chk("a78", add_a, 78);

    // adder never acks
    ack_mode = 1000;
    press(4'hC); press(4'h1); press(4'hA); press(4'h2);
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    n = 0;
    repeat (20) begin
      if (add_req) n++;
      cyc(1'b0, 4'h0, 1'b0, 1'b0);
    end
    chk("tmo_len", n, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_disp", disp_value, 0);
    chk("tmo_req", add_req, 0);
    press(4'h5);
    chk("err_clr", err, 0);
    chk("a5", add_a, 5);

    // clear beats a simultaneous ack
    press(4'hC); press(4'h1); press(4'hA); press(4'h2);
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0, 1'b1);
    chk("clr_req", add_req, 0);
    chk("clr_sel", disp_sel, 0);
    chk("clr_disp", disp_value, 0);
    chk("clr_a", add_a, 0);

    // reset mid-entry, then ignored codes
    press(4'h5); press(4'hA);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("mrst_a", add_a, 0);
    chk("mrst_sel", disp_sel, 0);
    press(4'h3); press(4'hD); press(4'hE); press(4'hF);
    chk("dEF_a", add_a, 3);
    chk("dEF_sel", disp_sel, 0);
    press(4'hA);
    chk("dEF_plus", disp_sel, 1);

    // random traffic
    ack_mode = -1;
    repeat (3000) begin
      w = int'($urandom_range(0, 99));
      if (w < 60)      kc = 4'($urandom_range(0, 9));
      else if (w < 75) kc = 4'hA;
      else if (w < 90) kc = 4'hB;
      else if (w < 95) kc = 4'hC;
      else             kc = 4'(13 + $urandom_range(0, 2));
      cyc(($urandom_range(0, 2) == 0), kc,
          ($urandom_range(0, 499) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
